mem_port_arbiter: RTL and testbench

- Shares one single-port memory between two requesters: instruction fetch (read-only) and data load/store.
- Sits between the program-counter/fetch path and the execute-stage memory access, so instruction and data storage can live in one memory instance.
- Data requests have fixed priority over fetch, with a starvation guard for fetch.
- One transaction is outstanding at a time; read responses are registered and routed back to the requester that issued them.

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between instruction fetch and data access
// Data has fixed priority; fetch is forced through after MAX_WAIT consecutive denials.
module mem_port_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read_en,
   output logic              mem_write_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);
   localparam int SW = $clog2(MAX_WAIT + 1);
   localparam int LW = $clog2(MEM_LAT + 1);

   typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

   state_t        state, state_nx;
   logic [LW-1:0] lat_cnt;
   logic          owner;
   logic [SW-1:0] starve_cnt;
   logic          f_win, d_win, rd_issue, rd_done;

   // Gating with rst_n keeps grants and strobes low while reset is held.
   always_comb begin
      f_win = 1'b0;
      d_win = 1'b0;
      if (rst_n && state == IDLE) begin
         if (d_req && starve_cnt < SW'(MAX_WAIT)) d_win = 1'b1;
         else if (if_req)                         f_win = 1'b1;
         else if (d_req)                          d_win = 1'b1;
      end
   end

   assign rd_issue = f_win | (d_win & ~d_we);
   assign rd_done  = (state == RD_WAIT) && (lat_cnt == LW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (rd_issue) state_nx = RD_WAIT;
         RD_WAIT: if (rd_done)  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      if_gnt         = f_win;
      d_gnt          = d_win;
      mem_read_en    = rd_issue;
      mem_write_en   = d_win & d_we;
      mem_addr       = '0;
      mem_write_data = '0;
      if (f_win)      mem_addr = if_addr;
      else if (d_win) mem_addr = d_addr;
      if (d_win & d_we) mem_write_data = d_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_cnt   <= '0;
         owner     <= 1'b0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
      end else begin
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if (rd_issue) begin
            owner   <= d_win;
            lat_cnt <= LW'(MEM_LAT);
         end else if (state == RD_WAIT) begin
            lat_cnt <= lat_cnt - LW'(1);
            // Only the owner's data register is written; the other keeps its value.
            if (rd_done) begin
               if (owner) begin
                  d_rdata  <= mem_read_data;
                  d_rvalid <= 1'b1;
               end else begin
                  if_rdata  <= mem_read_data;
                  if_rvalid <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        starve_cnt <= '0;
      else if (!if_req || if_gnt)        starve_cnt <= '0;
      else if (starve_cnt < SW'(MAX_WAIT)) starve_cnt <= starve_cnt + SW'(1);
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed scenarios plus a randomized run against a cycle-count reference model.
module tb_mem_port_arbiter;
   localparam int MAXW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   int n_run = 0;
   int n_fail = 0;

   logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
   logic [31:0] a_if_addr = '0, a_d_addr = '0, a_d_wdata = '0;
   logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_read_en, a_mem_write_en;
   logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_write_data, a_mem_read_data;

   logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
   logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0;
   logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_read_en, b_mem_write_en;
   logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_write_data, b_mem_read_data;

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h40) return 32'h00A00093;
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // Memory models: data appears exactly MEM_LAT cycles after the read strobe, garbage otherwise.
   logic        a_pv = 0;
   logic [31:0] a_pa = '0;
   always @(posedge clk) begin
      a_pv <= a_mem_read_en;
      a_pa <= a_mem_addr;
   end
   assign a_mem_read_data = a_pv ? memf(a_pa) : (32'hBAD00000 ^ cyc);

   logic [2:0]  b_pv = '0;
   logic [31:0] b_pa0 = '0, b_pa1 = '0, b_pa2 = '0;
   always @(posedge clk) begin
      b_pv  <= {b_pv[1:0], b_mem_read_en};
      b_pa0 <= b_mem_addr;
      b_pa1 <= b_pa0;
      b_pa2 <= b_pa1;
   end
   assign b_mem_read_data = b_pv[2] ? memf(b_pa2) : (32'hBAD10000 ^ cyc);

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(MAXW)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
      .mem_read_en(a_mem_read_en), .mem_write_en(a_mem_write_en), .mem_addr(a_mem_addr),
      .mem_write_data(a_mem_write_data), .mem_read_data(a_mem_read_data));

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_WAIT(MAXW)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
      .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
      .mem_read_en(b_mem_read_en), .mem_write_en(b_mem_write_en), .mem_addr(b_mem_addr),
      .mem_write_data(b_mem_write_data), .mem_read_data(b_mem_read_data));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a(input int n);
      a_if_req = 0;
      a_d_req = 0;
      a_d_we = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic test_reset();
      a_if_req = 1; a_d_req = 1; a_if_addr = 32'h10; a_d_addr = 32'h20;
      #12;
      n_run++; if ({a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en, a_if_rvalid, a_d_rvalid} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en, a_if_rvalid, a_d_rvalid}); end
      n_run++; if ({a_if_rdata, a_d_rdata, a_mem_addr} !== 96'b0) begin
         n_fail++; $display("FAIL reset_data: if_rdata %h d_rdata %h mem_addr %h want 0", a_if_rdata, a_d_rdata, a_mem_addr); end
      @(posedge clk); #1;
      a_if_req = 0; a_d_req = 0;
      rst_n = 1;
      idle_a(1);
   endtask

   task automatic test_lone_fetch();
      a_if_req = 1; a_if_addr = 32'h40;
      @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en} !== 4'b1010) begin
         n_fail++; $display("FAIL lone_grant: got %b want 1010", {a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en}); end
      n_run++; if (a_mem_addr !== 32'h40) begin n_fail++; $display("FAIL lone_addr: got %h want 00000040", a_mem_addr); end
      tick(); a_if_req = 0;
      @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid} !== 4'b0) begin
         n_fail++; $display("FAIL lone_wait: got %b want 0000", {a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid}); end
      tick(); @(negedge clk);
      n_run++; if ({a_if_rvalid, a_d_rvalid} !== 2'b10) begin
         n_fail++; $display("FAIL lone_rvalid: got %b want 10", {a_if_rvalid, a_d_rvalid}); end
      n_run++; if (a_if_rdata !== 32'h00A00093) begin n_fail++; $display("FAIL lone_rdata: got %h want 00a00093", a_if_rdata); end
      tick(); @(negedge clk);
      n_run++; if (a_if_rvalid !== 1'b0 || a_if_rdata !== 32'h00A00093) begin
         n_fail++; $display("FAIL lone_hold: rvalid %b rdata %h want 0 00a00093", a_if_rvalid, a_if_rdata); end
      idle_a(1);
   endtask

   task automatic test_simultaneous();
      a_if_req = 1; a_if_addr = 32'h44; a_d_req = 1; a_d_we = 0; a_d_addr = 32'h100;
      @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt} !== 2'b01) begin n_fail++; $display("FAIL sim_c0_gnt: got %b want 01", {a_if_gnt, a_d_gnt}); end
      tick(); a_d_req = 0;
      @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt} !== 2'b00) begin n_fail++; $display("FAIL sim_c1_gnt: got %b want 00", {a_if_gnt, a_d_gnt}); end
      tick(); @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt, a_d_rvalid, a_if_rvalid} !== 4'b1010) begin
         n_fail++; $display("FAIL sim_c2: got %b want 1010", {a_if_gnt, a_d_gnt, a_d_rvalid, a_if_rvalid}); end
      n_run++; if (a_d_rdata !== memf(32'h100) || a_mem_addr !== 32'h44) begin
         n_fail++; $display("FAIL sim_c2_data: d_rdata %h addr %h want %h 00000044", a_d_rdata, a_mem_addr, memf(32'h100)); end
      tick(); a_if_req = 0;
      tick(); @(negedge clk);
      n_run++; if ({a_if_rvalid, a_d_rvalid} !== 2'b10 || a_if_rdata !== memf(32'h44)) begin
         n_fail++; $display("FAIL sim_c4: rvalids %b rdata %h want 10 %h", {a_if_rvalid, a_d_rvalid}, a_if_rdata, memf(32'h44)); end
      n_run++; if (a_d_rdata !== memf(32'h100)) begin n_fail++; $display("FAIL sim_d_hold: got %h want %h", a_d_rdata, memf(32'h100)); end
      idle_a(1);
   endtask

   task automatic test_write_then_fetch();
      a_d_req = 1; a_d_we = 1; a_d_addr = 32'h200; a_d_wdata = 32'hDEADBEEF;
      a_if_req = 1; a_if_addr = 32'h48;
      @(negedge clk);
      n_run++; if ({a_d_gnt, a_mem_write_en, a_mem_read_en} !== 3'b110 || a_mem_addr !== 32'h200 || a_mem_write_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL wr_c0: ctl %b addr %h wdata %h want 110 200 deadbeef", {a_d_gnt, a_mem_write_en, a_mem_read_en}, a_mem_addr, a_mem_write_data); end
      tick(); a_d_req = 0; a_d_we = 0;
      @(negedge clk);
      n_run++; if ({a_if_gnt, a_mem_write_en, a_d_rvalid} !== 3'b100 || a_mem_write_data !== 32'h0) begin
         n_fail++; $display("FAIL wr_c1: ctl %b wdata %h want 100 0", {a_if_gnt, a_mem_write_en, a_d_rvalid}, a_mem_write_data); end
      tick(); a_if_req = 0;
      @(negedge clk);
      n_run++; if (a_d_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b want 0", a_d_rvalid); end
      idle_a(2);
   endtask

   task automatic test_starvation();
      a_if_req = 1; a_if_addr = 32'h4C; a_d_req = 1; a_d_we = 1; a_d_addr = 32'h300; a_d_wdata = 32'h1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_run++; if ({a_if_gnt, a_d_gnt} !== ((c < 4) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL starve_c%0d: got %b want %b", c, {a_if_gnt, a_d_gnt}, (c < 4) ? 2'b01 : 2'b10); end
         tick(); a_d_addr = a_d_addr + 32'd4; a_d_wdata = a_d_wdata + 32'd1;
      end
      a_if_addr = 32'h60;
      @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt} !== 2'b00) begin n_fail++; $display("FAIL starve_rdwait: got %b want 00", {a_if_gnt, a_d_gnt}); end
      tick(); @(negedge clk);
      n_run++; if ({a_if_gnt, a_d_gnt, a_if_rvalid} !== 3'b011 || a_if_rdata !== memf(32'h4C)) begin
         n_fail++; $display("FAIL starve_clear: ctl %b rdata %h want 011 %h", {a_if_gnt, a_d_gnt, a_if_rvalid}, a_if_rdata, memf(32'h4C)); end
      tick(); a_d_req = 0;
      @(negedge clk);
      n_run++; if (a_if_gnt !== 1'b1 || a_mem_addr !== 32'h60) begin
         n_fail++; $display("FAIL starve_refetch: gnt %b addr %h want 1 00000060", a_if_gnt, a_mem_addr); end
      idle_a(3);
   endtask

   task automatic test_reset_rd_wait();
      a_if_req = 1; a_if_addr = 32'h50;
      @(negedge clk);
      n_run++; if (a_if_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_pre_gnt: got %b want 1", a_if_gnt); end
      tick();
      a_d_req = 1; a_d_we = 1; a_d_addr = 32'h70;
      rst_n = 0;
      #1;
      n_run++; if ({a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en, a_if_rvalid, a_d_rvalid} !== 6'b0 || a_mem_addr !== 32'h0) begin
         n_fail++; $display("FAIL rst_async_ctl: got %b addr %h want 000000 0", {a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en, a_if_rvalid, a_d_rvalid}, a_mem_addr); end
      n_run++; if ({a_if_rdata, a_d_rdata} !== 64'b0) begin
         n_fail++; $display("FAIL rst_async_data: if %h d %h want 0 0", a_if_rdata, a_d_rdata); end
      tick(); @(negedge clk);
      n_run++; if (a_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_no_rvalid: got %b want 0", a_if_rvalid); end
      tick();
      a_d_req = 0; a_d_we = 0; a_if_addr = 32'h54;
      rst_n = 1;
      @(negedge clk);
      n_run++; if (a_if_gnt !== 1'b1 || a_mem_addr !== 32'h54) begin
         n_fail++; $display("FAIL rst_first_gnt: gnt %b addr %h want 1 00000054", a_if_gnt, a_mem_addr); end
      tick(); a_if_req = 0;
      @(negedge clk);
      n_run++; if (a_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_stale_rvalid: got %b want 0", a_if_rvalid); end
      tick(); @(negedge clk);
      n_run++; if (a_if_rvalid !== 1'b1 || a_if_rdata !== memf(32'h54)) begin
         n_fail++; $display("FAIL rst_new_read: rvalid %b rdata %h want 1 %h", a_if_rvalid, a_if_rdata, memf(32'h54)); end
      idle_a(2);
   endtask

   task automatic test_back_to_back();
      int          n = 0;
      logic        eg = 0;
      logic        ev;
      logic [31:0] last = '0;
      for (int k = 0; k < 14; k++) begin
         if (k == 0) begin
            b_d_req = 1; b_d_we = 0; b_d_addr = 32'h300;
         end else if (eg) begin
            n++;
            if (n == 3) b_d_req = 0;
            else b_d_addr = 32'h300 + 32'(4 * n);
         end
         @(negedge clk);
         eg = (k % 4 == 0) && (k <= 8);
         ev = (k % 4 == 0) && (k >= 4) && (k <= 12);
         if (ev) last = memf(32'h300 + 32'(4 * (k / 4 - 1)));
         n_run++; if ({b_d_gnt, b_mem_read_en, b_d_rvalid} !== {eg, eg, ev}) begin
            n_fail++; $display("FAIL b2b_k%0d_ctl: got %b want %b", k, {b_d_gnt, b_mem_read_en, b_d_rvalid}, {eg, eg, ev}); end
         n_run++; if (b_d_rdata !== last) begin
            n_fail++; $display("FAIL b2b_k%0d_rdata: got %h want %h", k, b_d_rdata, last); end
         tick();
      end
      b_d_req = 0;
   endtask

   task automatic test_random(input int ncyc);
      int          busy = 0, starve = 0, pend_due = 0;
      logic        pend_v = 0, pend_own = 0;
      logic [31:0] pend_data = '0, m_if_rd = '0, m_d_rd = '0;
      logic        eg_i = 0, eg_d = 0, e_rd, e_wr, e_irv, e_drv;
      logic [31:0] e_addr, e_wd;
      rst_n = 0;
      idle_a(1);
      rst_n = 1;
      for (int k = 0; k < ncyc; k++) begin
         if (a_if_req && eg_i) a_if_req = 0;
         if (a_d_req && eg_d) a_d_req = 0;
         if (!a_if_req && $urandom_range(0, 2) == 0) begin
            a_if_req = 1; a_if_addr = $urandom & 32'h3FC;
         end else if (a_if_req && $urandom_range(0, 15) == 0) a_if_req = 0;
         if (!a_d_req && $urandom_range(0, 1) == 0) begin
            a_d_req = 1; a_d_we = $urandom_range(0, 1) == 1; a_d_addr = $urandom & 32'h3FC; a_d_wdata = $urandom;
         end else if (a_d_req && $urandom_range(0, 15) == 0) a_d_req = 0;
         @(negedge clk);
         eg_i = 0; eg_d = 0;
         if (busy == 0) begin
            if (a_d_req && starve < MAXW) eg_d = 1;
            else if (a_if_req)            eg_i = 1;
            else if (a_d_req)             eg_d = 1;
         end
         e_rd   = eg_i || (eg_d && !a_d_we);
         e_wr   = eg_d && a_d_we;
         e_addr = eg_i ? a_if_addr : (eg_d ? a_d_addr : 32'h0);
         e_wd   = e_wr ? a_d_wdata : 32'h0;
         e_irv  = pend_v && pend_due == k && !pend_own;
         e_drv  = pend_v && pend_due == k && pend_own;
         if (pend_v && pend_due == k) begin
            if (pend_own) m_d_rd = pend_data;
            else          m_if_rd = pend_data;
            pend_v = 0;
         end
         n_run++; if ({a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en, a_if_rvalid, a_d_rvalid} !== {eg_i, eg_d, e_rd, e_wr, e_irv, e_drv}) begin
            n_fail++; $display("FAIL rnd_k%0d_ctl: got %b want %b", k, {a_if_gnt, a_d_gnt, a_mem_read_en, a_mem_write_en, a_if_rvalid, a_d_rvalid}, {eg_i, eg_d, e_rd, e_wr, e_irv, e_drv}); end
         n_run++; if (a_mem_addr !== e_addr || a_mem_write_data !== e_wd) begin
            n_fail++; $display("FAIL rnd_k%0d_mem: addr %h wdata %h want %h %h", k, a_mem_addr, a_mem_write_data, e_addr, e_wd); end
         n_run++; if (a_if_rdata !== m_if_rd || a_d_rdata !== m_d_rd) begin
            n_fail++; $display("FAIL rnd_k%0d_rdata: if %h d %h want %h %h", k, a_if_rdata, a_d_rdata, m_if_rd, m_d_rd); end
         if (e_rd) begin
            busy = 1; pend_v = 1; pend_due = k + 2; pend_own = eg_d; pend_data = memf(e_addr);
         end else if (busy > 0) busy--;
         starve = (a_if_req && !eg_i) ? ((starve < MAXW) ? starve + 1 : starve) : 0;
         tick();
      end
      idle_a(3);
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_write_then_fetch();
      test_starvation();
      test_reset_rd_wait();
      test_back_to_back();
      test_random(400);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
